// File: rtl/mux_key_default_reg_pkg.sv
// Shared sizing helpers for the key/data lookup mux family.
// Widths are purely parametric, so only a pair-width helper lives here.
package mux_key_default_reg_pkg;

    function automatic int pair_len(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

endpackage

// File: rtl/mux_key_default_reg_if.sv
// Lookup bus: key, default and flat table in; combinational and registered results out.
// The master drives the lookup inputs, and the slave (the mux) returns the results.
interface mux_key_default_reg_if
    import mux_key_default_reg_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
);
    localparam int PAIR = pair_len(KEY_LEN, DATA_LEN);

    logic [KEY_LEN-1:0]       key;
    logic [DATA_LEN-1:0]      default_out;
    logic [NR_KEY*PAIR-1:0]   lut;
    logic [DATA_LEN-1:0]      out;
    logic                     hit;
    logic [DATA_LEN-1:0]      out_q;
    logic                     hit_q;

    modport master (
        output key, default_out, lut,
        input  out, hit, out_q, hit_q
    );

    modport slave (
        input  key, default_out, lut,
        output out, hit, out_q, hit_q
    );
endinterface

// File: rtl/mux_key_core.sv
// Combinational key match across a flat table, OR-combining data of every matching entry.
// Zero latency. Falls back to default_out when nothing matches.
module mux_key_core
    import mux_key_default_reg_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                           key,
    input  logic [DATA_LEN-1:0]                          default_out,
    input  logic [NR_KEY*pair_len(KEY_LEN, DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                          out,
    output logic                                         hit
);
    localparam int PAIR = pair_len(KEY_LEN, DATA_LEN);

    logic [DATA_LEN-1:0] data_or;

    // Duplicate keys are legal: every matching entry contributes, so order does not matter.
    always_comb begin
        hit     = 1'b0;
        data_or = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut[PAIR*i + DATA_LEN +: KEY_LEN] == key) begin
                hit     = 1'b1;
                data_or = data_or | lut[PAIR*i +: DATA_LEN];
            end
        end
        out = hit ? data_or : default_out;
    end

endmodule

// File: rtl/mux_key_default_reg.sv
// Key lookup mux with a combinational result plus a one-cycle registered copy.
// out/hit follow inputs in the same cycle. out_q/hit_q update every edge and clear on rst.
module mux_key_default_reg
    import mux_key_default_reg_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_key_default_reg_if.slave bus
);
    logic [DATA_LEN-1:0] out_c;
    logic                hit_c;

    mux_key_core #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_core (
        .key         (bus.key),
        .default_out (bus.default_out),
        .lut         (bus.lut),
        .out         (out_c),
        .hit         (hit_c)
    );

    assign bus.out = out_c;
    assign bus.hit = hit_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_q <= '0;
            bus.hit_q <= 1'b0;
        end else begin
            bus.out_q <= out_c;
            bus.hit_q <= hit_c;
        end
    end

endmodule

// File: tb/tb_mux_key_default_reg.sv
// Directed checks of the lookup mux on three table configurations sharing one clock and reset.
module tb_mux_key_default_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_key_default_reg_if #(.NR_KEY(3), .KEY_LEN(3), .DATA_LEN(3)) ifa ();
    mux_key_default_reg_if #(.NR_KEY(3), .KEY_LEN(5), .DATA_LEN(3)) ifb ();
    mux_key_default_reg_if #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(8)) ifc ();

    mux_key_default_reg #(.NR_KEY(3), .KEY_LEN(3), .DATA_LEN(3)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    mux_key_default_reg #(.NR_KEY(3), .KEY_LEN(5), .DATA_LEN(3)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );
    mux_key_default_reg #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(8)) dut_c (
        .clk (clk), .rst (rst), .bus (ifc.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       k;
        logic [7:0] exp_prev;
        logic       exp_prev_hit;

        rst             = 1'b1;
        ifa.lut         = {3'b001, 3'b101, 3'b010, 3'b110, 3'b001, 3'b111};
        ifa.key         = 3'b010;
        ifa.default_out = 3'b101;
        ifb.lut         = {5'b11001, 3'b010, 5'b11011, 3'b001, 5'b11000, 3'b000};
        ifb.key         = 5'b11000;
        ifb.default_out = 3'b000;
        ifc.lut         = {1'b1, 8'hA5};
        ifc.key         = 1'b1;
        ifc.default_out = 8'h3C;

        // reset state
        edge_then_settle();
        check("rst_a_out_q", 32'(ifa.out_q), 32'h0);
        check("rst_a_hit_q", 32'(ifa.hit_q), 32'h0);
        check("rst_c_out_q", 32'(ifc.out_q), 32'h0);
        rst = 1'b0;

        // table A hit and registered copy
        ifa.key = 3'b010;
        #1;
        check("a_010_out", 32'(ifa.out), 32'h6);
        check("a_010_hit", 32'(ifa.hit), 32'h1);
        edge_then_settle();
        check("a_010_out_q", 32'(ifa.out_q), 32'h6);
        check("a_010_hit_q", 32'(ifa.hit_q), 32'h1);

        // duplicate key OR-combines 101|111
        ifa.key = 3'b001;
        #1;
        check("a_dup_out", 32'(ifa.out), 32'h7);
        check("a_dup_hit", 32'(ifa.hit), 32'h1);

        // miss falls back to default, tracking default changes combinationally
        ifa.key = 3'b000;
        #1;
        check("a_miss_out", 32'(ifa.out), 32'h5);
        check("a_miss_hit", 32'(ifa.hit), 32'h0);
        ifa.default_out = 3'b011;
        #1;
        check("a_miss_newdef", 32'(ifa.out), 32'h3);
        edge_then_settle();
        check("a_miss_out_q", 32'(ifa.out_q), 32'h3);
        check("a_miss_hit_q", 32'(ifa.hit_q), 32'h0);

        // table B: zero-data entry still hits
        ifb.key = 5'b11000;
        #1;
        check("b_zero_out", 32'(ifb.out), 32'h0);
        check("b_zero_hit", 32'(ifb.hit), 32'h1);
        ifb.key = 5'b00100;
        #1;
        check("b_miss_out", 32'(ifb.out), 32'h0);
        check("b_miss_hit", 32'(ifb.hit), 32'h0);
        ifb.key = 5'b11001;
        #1;
        check("b_top_out", 32'(ifb.out), 32'h2);
        ifb.key = 5'b11011;
        #1;
        check("b_mid_out", 32'(ifb.out), 32'h1);

        // mid-stream reset clears only the register
        ifa.key         = 3'b010;
        ifa.default_out = 3'b101;
        repeat (3) edge_then_settle();
        check("pre_rst_out_q", 32'(ifa.out_q), 32'h6);
        rst = 1'b1;
        edge_then_settle();
        check("mid_rst_out_q", 32'(ifa.out_q), 32'h0);
        check("mid_rst_hit_q", 32'(ifa.hit_q), 32'h0);
        check("mid_rst_out", 32'(ifa.out), 32'h6);
        check("mid_rst_hit", 32'(ifa.hit), 32'h1);
        rst = 1'b0;
        edge_then_settle();
        check("post_rst_out_q", 32'(ifa.out_q), 32'h6);
        check("post_rst_hit_q", 32'(ifa.hit_q), 32'h1);

        // single-entry table
        ifc.key = 1'b1;
        #1;
        check("c_hit_out", 32'(ifc.out), 32'hA5);
        check("c_hit_hit", 32'(ifc.hit), 32'h1);
        ifc.key = 1'b0;
        #1;
        check("c_miss_out", 32'(ifc.out), 32'h3C);
        check("c_miss_hit", 32'(ifc.hit), 32'h0);

        // random sweep: out_q must follow the model of the previous cycle's key
        for (int n = 0; n < 24; n++) begin
            k = 1'($urandom_range(0, 1));
            ifc.key = k;
            #1;
            exp_prev     = k ? 8'hA5 : 8'h3C;
            exp_prev_hit = k;
            check("c_sweep_out", 32'(ifc.out), 32'(exp_prev));
            edge_then_settle();
            check("c_sweep_out_q", 32'(ifc.out_q), 32'(exp_prev));
            check("c_sweep_hit_q", 32'(ifc.hit_q), 32'(exp_prev_hit));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
